// File: rtl/csr_pkg.sv
// Shared encodings for the machine-mode CSR unit: op codes, CSR addresses,
// mstatus field positions and the request FSM states.
package csr_pkg;

    localparam logic [2:0] CSR_OP_RW    = 3'd0;
    localparam logic [2:0] CSR_OP_RS    = 3'd1;
    localparam logic [2:0] CSR_OP_RC    = 3'd2;
    localparam logic [2:0] CSR_OP_ECALL = 3'd3;
    localparam logic [2:0] CSR_OP_MRET  = 3'd4;

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } csr_state_e;

endpackage

// File: rtl/csr_regfile.sv
// CSR storage with address decode and write masks. One combinational read
// port, one write port, plus dedicated trap-entry and mret update strobes.
module csr_regfile
    import csr_pkg::*;
#(
    parameter int              XLEN        = 64,
    parameter logic [XLEN-1:0] MTVEC_RESET = '0,
    parameter logic [XLEN-1:0] ECALL_CAUSE = XLEN'(11)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [11:0]     addr_i,
    output logic [XLEN-1:0] rdata_o,
    output logic            hit_o,
    input  logic            we_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic            trap_i,
    input  logic [XLEN-1:0] trap_pc_i,
    input  logic            mret_i,
    output logic [XLEN-1:0] mtvec_o,
    output logic [XLEN-1:0] mepc_o
);

    localparam logic [XLEN-1:0] ALIGN4_MASK = ~XLEN'(3);

    logic            mie_q;
    logic            mpie_q;
    logic [XLEN-1:0] mtvec_q;
    logic [XLEN-1:0] mscratch_q;
    logic [XLEN-1:0] mepc_q;
    logic [XLEN-1:0] mcause_q;
    logic [XLEN-1:0] mstatus_rd;

    // Only MIE/MPIE are stored; MPP is hardwired to machine mode.
    always_comb begin
        mstatus_rd                                = '0;
        mstatus_rd[MSTATUS_MIE]                   = mie_q;
        mstatus_rd[MSTATUS_MPIE]                  = mpie_q;
        mstatus_rd[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    end

    always_comb begin
        rdata_o = '0;
        hit_o   = 1'b1;
        case (addr_i)
            CSR_MSTATUS:  rdata_o = mstatus_rd;
            CSR_MTVEC:    rdata_o = mtvec_q;
            CSR_MSCRATCH: rdata_o = mscratch_q;
            CSR_MEPC:     rdata_o = mepc_q;
            CSR_MCAUSE:   rdata_o = mcause_q;
            default:      hit_o   = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mie_q      <= 1'b0;
            mpie_q     <= 1'b0;
            mtvec_q    <= MTVEC_RESET;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
        end else if (trap_i) begin
            mepc_q   <= trap_pc_i & ALIGN4_MASK;
            mcause_q <= ECALL_CAUSE;
            mpie_q   <= mie_q;
            mie_q    <= 1'b0;
        end else if (mret_i) begin
            mie_q  <= mpie_q;
            mpie_q <= 1'b1;
        end else if (we_i) begin
            case (addr_i)
                CSR_MSTATUS: begin
                    mie_q  <= wdata_i[MSTATUS_MIE];
                    mpie_q <= wdata_i[MSTATUS_MPIE];
                end
                CSR_MTVEC:    mtvec_q    <= wdata_i & ALIGN4_MASK;
                CSR_MSCRATCH: mscratch_q <= wdata_i;
                CSR_MEPC:     mepc_q     <= wdata_i & ALIGN4_MASK;
                CSR_MCAUSE:   mcause_q   <= wdata_i;
                default:      ;
            endcase
        end
    end

    assign mtvec_o = mtvec_q;
    assign mepc_o  = mepc_q;

endmodule

// File: rtl/csr_unit.sv
// Machine-mode CSR unit: latches one request, executes it in a single EXEC
// cycle against csr_regfile, and holds the registered response until taken.
module csr_unit
    import csr_pkg::*;
#(
    parameter int              XLEN        = 64,
    parameter logic [XLEN-1:0] MTVEC_RESET = '0,
    parameter logic [XLEN-1:0] ECALL_CAUSE = XLEN'(11)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_op,
    input  logic [11:0]     req_addr,
    input  logic [XLEN-1:0] req_wdata,
    input  logic            req_wsuppress,
    input  logic [XLEN-1:0] req_pc,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_illegal,
    output logic            rsp_redirect,
    output logic [XLEN-1:0] rsp_target
);

    csr_state_e      state_q;
    logic [2:0]      op_q;
    logic [11:0]     addr_q;
    logic [XLEN-1:0] wdata_q;
    logic            wsup_q;
    logic [XLEN-1:0] pc_q;

    logic            rsp_valid_q;
    logic [XLEN-1:0] rsp_rdata_q;
    logic            rsp_illegal_q;
    logic            rsp_redirect_q;
    logic [XLEN-1:0] rsp_target_q;

    logic [XLEN-1:0] csr_rdata;
    logic            csr_hit;
    logic [XLEN-1:0] mtvec;
    logic [XLEN-1:0] mepc;

    logic            is_csr_op;
    logic            exec;
    logic            csr_we;
    logic            trap;
    logic            mret;
    logic [XLEN-1:0] new_val;
    logic [XLEN-1:0] rsp_rdata_d;
    logic            rsp_illegal_d;
    logic            rsp_redirect_d;
    logic [XLEN-1:0] rsp_target_d;

    csr_regfile #(
        .XLEN        (XLEN),
        .MTVEC_RESET (MTVEC_RESET),
        .ECALL_CAUSE (ECALL_CAUSE)
    ) u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .addr_i    (addr_q),
        .rdata_o   (csr_rdata),
        .hit_o     (csr_hit),
        .we_i      (csr_we),
        .wdata_i   (new_val),
        .trap_i    (trap),
        .trap_pc_i (pc_q),
        .mret_i    (mret),
        .mtvec_o   (mtvec),
        .mepc_o    (mepc)
    );

    always_comb begin
        exec      = (state_q == ST_EXEC);
        is_csr_op = (op_q == CSR_OP_RW) || (op_q == CSR_OP_RS) || (op_q == CSR_OP_RC);

        new_val = wdata_q;
        case (op_q)
            CSR_OP_RS: new_val = csr_rdata | wdata_q;
            CSR_OP_RC: new_val = csr_rdata & ~wdata_q;
            default:   new_val = wdata_q;
        endcase

        // CSRRW writes even from x0; set/clear with a zero source are pure reads.
        csr_we = exec && is_csr_op && csr_hit && ((op_q == CSR_OP_RW) || !wsup_q);
        trap   = exec && (op_q == CSR_OP_ECALL);
        mret   = exec && (op_q == CSR_OP_MRET);

        rsp_rdata_d    = (is_csr_op && csr_hit) ? csr_rdata : '0;
        rsp_illegal_d  = (is_csr_op && !csr_hit) || (op_q > CSR_OP_MRET);
        rsp_redirect_d = (op_q == CSR_OP_ECALL) || (op_q == CSR_OP_MRET);
        rsp_target_d   = '0;
        if (op_q == CSR_OP_ECALL) begin
            rsp_target_d = {mtvec[XLEN-1:2], 2'b00};
        end else if (op_q == CSR_OP_MRET) begin
            rsp_target_d = mepc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            op_q           <= '0;
            addr_q         <= '0;
            wdata_q        <= '0;
            wsup_q         <= 1'b0;
            pc_q           <= '0;
            rsp_valid_q    <= 1'b0;
            rsp_rdata_q    <= '0;
            rsp_illegal_q  <= 1'b0;
            rsp_redirect_q <= 1'b0;
            rsp_target_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        op_q    <= req_op;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        wsup_q  <= req_wsuppress;
                        pc_q    <= req_pc;
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    rsp_valid_q    <= 1'b1;
                    rsp_rdata_q    <= rsp_rdata_d;
                    rsp_illegal_q  <= rsp_illegal_d;
                    rsp_redirect_q <= rsp_redirect_d;
                    rsp_target_q   <= rsp_target_d;
                    state_q        <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign req_ready    = rst_n && (state_q == ST_IDLE);
    assign rsp_valid    = rsp_valid_q;
    assign rsp_rdata    = rsp_rdata_q;
    assign rsp_illegal  = rsp_illegal_q;
    assign rsp_redirect = rsp_redirect_q;
    assign rsp_target   = rsp_target_q;

endmodule

// File: tb/tb_csr_unit.sv
// Scoreboard bench for csr_unit: a reference CSR model predicts each response
// when the request is driven; a monitor pops and compares on each handshake.
module tb_csr_unit;
    import csr_pkg::*;

    localparam int XLEN = 64;
    localparam logic [63:0] MTVEC_RST = 64'h0;

    typedef struct {
        logic [63:0] rdata;
        logic        illegal;
        logic        redirect;
        logic [63:0] target;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = '0;
    logic [11:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic        req_wsuppress = 1'b0;
    logic [63:0] req_pc = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [63:0] rsp_rdata;
    logic        rsp_illegal;
    logic        rsp_redirect;
    logic [63:0] rsp_target;

    int n_checks = 0;
    int n_errors = 0;
    exp_t sb_q[$];

    // Reference model state
    logic        m_mie, m_mpie;
    logic [63:0] m_mtvec, m_mscratch, m_mepc, m_mcause;

    csr_unit #(
        .XLEN        (XLEN),
        .MTVEC_RESET (MTVEC_RST),
        .ECALL_CAUSE (64'd11)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_op        (req_op),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .req_wsuppress (req_wsuppress),
        .req_pc        (req_pc),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_rdata     (rsp_rdata),
        .rsp_illegal   (rsp_illegal),
        .rsp_redirect  (rsp_redirect),
        .rsp_target    (rsp_target)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_mie = 1'b0; m_mpie = 1'b0;
        m_mtvec = MTVEC_RST; m_mscratch = '0; m_mepc = '0; m_mcause = '0;
    endtask

    task automatic model_read(input logic [11:0] a, output logic [63:0] v, output bit hit);
        hit = 1'b1;
        v   = '0;
        case (a)
            12'h300: v = 64'h1800 | (64'(m_mpie) << 7) | (64'(m_mie) << 3);
            12'h305: v = m_mtvec;
            12'h340: v = m_mscratch;
            12'h341: v = m_mepc;
            12'h342: v = m_mcause;
            default: hit = 1'b0;
        endcase
    endtask

    task automatic model_write(input logic [11:0] a, input logic [63:0] v);
        case (a)
            12'h300: begin m_mie = v[3]; m_mpie = v[7]; end
            12'h305: m_mtvec = {v[63:2], 2'b00};
            12'h340: m_mscratch = v;
            12'h341: m_mepc = {v[63:2], 2'b00};
            12'h342: m_mcause = v;
            default: ;
        endcase
    endtask

    task automatic predict(input logic [2:0] op, input logic [11:0] a, input logic [63:0] wd,
                           input logic ws, input logic [63:0] pc, output exp_t e);
        logic [63:0] old;
        bit hit;
        e.rdata = '0; e.illegal = 1'b0; e.redirect = 1'b0; e.target = '0;
        if (op <= 3'd2) begin
            model_read(a, old, hit);
            if (!hit) begin
                e.illegal = 1'b1;
            end else begin
                e.rdata = old;
                if (op == 3'd0) model_write(a, wd);
                else if (op == 3'd1 && !ws) model_write(a, old | wd);
                else if (op == 3'd2 && !ws) model_write(a, old & ~wd);
            end
        end else if (op == 3'd3) begin
            e.redirect = 1'b1;
            e.target   = {m_mtvec[63:2], 2'b00};
            m_mepc     = {pc[63:2], 2'b00};
            m_mcause   = 64'd11;
            m_mpie     = m_mie;
            m_mie      = 1'b0;
        end else if (op == 3'd4) begin
            e.redirect = 1'b1;
            e.target   = m_mepc;
            m_mie      = m_mpie;
            m_mpie     = 1'b1;
        end else begin
            e.illegal = 1'b1;
        end
    endtask

    task automatic send(input logic [2:0] op, input logic [11:0] a, input logic [63:0] wd,
                        input logic ws, input logic [63:0] pc, input bit wait_rsp);
        exp_t e;
        int n;
        predict(op, a, wd, ws, pc, e);
        sb_q.push_back(e);
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_addr = a;
        req_wdata = wd; req_wsuppress = ws; req_pc = pc;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_val("accept", 64'(req_ready), 64'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check_val("lat_exec_valid", 64'(rsp_valid), 64'd0);
        @(negedge clk);
        check_val("lat_resp_valid", 64'(rsp_valid), 64'd1);
        if (wait_rsp) begin
            n = 0;
            while (sb_q.size() != 0 && n < 50) begin
                @(negedge clk);
                n++;
            end
            check_val("rsp_drain", 64'(sb_q.size()), 64'd0);
        end
    endtask

    // Response monitor: compare on every completed handshake
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (sb_q.size() == 0) begin
                check_val("unexpected_rsp", 64'(rsp_valid), 64'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                $display("rsp rdata=0x%0h illegal=%0b redirect=%0b target=0x%0h",
                         rsp_rdata, rsp_illegal, rsp_redirect, rsp_target);
                check_val("rdata", rsp_rdata, e.rdata);
                check_val("illegal", 64'(rsp_illegal), 64'(e.illegal));
                check_val("redirect", 64'(rsp_redirect), 64'(e.redirect));
                check_val("target", rsp_target, e.target);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] addrs [6];
        exp_t held;
        model_reset();
        addrs[0] = 12'h300; addrs[1] = 12'h305; addrs[2] = 12'h340;
        addrs[3] = 12'h341; addrs[4] = 12'h342; addrs[5] = 12'h7C0;

        #3;
        check_val("reset_req_ready", 64'(req_ready), 64'd0);
        check_val("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        check_val("reset_rsp_illegal", 64'(rsp_illegal), 64'd0);
        check_val("reset_rsp_redirect", 64'(rsp_redirect), 64'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        // mtvec write/readback with low-bit masking and suppressed set
        send(CSR_OP_RW, 12'h305, 64'h80000103, 1'b0, 64'h0, 1'b1);
        send(CSR_OP_RS, 12'h305, 64'h0, 1'b1, 64'h0, 1'b1);

        // mstatus set/clear of MIE
        send(CSR_OP_RS, 12'h300, 64'h8, 1'b0, 64'h0, 1'b1);
        send(CSR_OP_RC, 12'h300, 64'h8, 1'b0, 64'h0, 1'b1);
        send(CSR_OP_RS, 12'h300, 64'h0, 1'b1, 64'h0, 1'b1);

        // ECALL with MIE=1, then CSR readback, then MRET
        send(CSR_OP_RS, 12'h300, 64'h8, 1'b0, 64'h0, 1'b1);
        send(CSR_OP_ECALL, 12'h123, 64'h0, 1'b0, 64'h80000040, 1'b1);
        send(CSR_OP_RS, 12'h341, 64'h0, 1'b1, 64'h0, 1'b1);
        send(CSR_OP_RS, 12'h342, 64'h0, 1'b1, 64'h0, 1'b1);
        send(CSR_OP_RS, 12'h300, 64'h0, 1'b1, 64'h0, 1'b1);
        send(CSR_OP_MRET, 12'h0, 64'h0, 1'b0, 64'h0, 1'b1);
        send(CSR_OP_RS, 12'h300, 64'h0, 1'b1, 64'h0, 1'b1);

        // Illegal address / reserved op leave mscratch intact
        send(CSR_OP_RW, 12'h340, 64'hDEADBEEF, 1'b0, 64'h0, 1'b1);
        send(CSR_OP_RW, 12'h7C0, 64'h55, 1'b0, 64'h0, 1'b1);
        send(3'd6, 12'h340, 64'h77, 1'b0, 64'h0, 1'b1);
        send(CSR_OP_RS, 12'h340, 64'hFF, 1'b1, 64'h0, 1'b1);
        send(CSR_OP_RW, 12'h340, 64'h0, 1'b1, 64'h0, 1'b1);
        send(CSR_OP_RW, 12'h341, 64'h1003, 1'b0, 64'h0, 1'b1);
        send(CSR_OP_RS, 12'h341, 64'h0, 1'b1, 64'h0, 1'b1);

        // Random mix over all ops and addresses
        for (int i = 0; i < 24; i++) begin
            send(3'($urandom_range(0, 7)), addrs[$urandom_range(0, 5)],
                 {$urandom, $urandom}, 1'($urandom_range(0, 1)),
                 {$urandom, $urandom}, 1'b1);
        end

        // Back-pressure: response held stable, then reset during RESP
        rsp_ready = 1'b0;
        send(CSR_OP_RW, 12'h305, 64'h1234, 1'b0, 64'h0, 1'b0);
        held = sb_q[0];
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_val("stall_valid", 64'(rsp_valid), 64'd1);
            check_val("stall_rdata", rsp_rdata, held.rdata);
            check_val("stall_req_ready", 64'(req_ready), 64'd0);
        end
        #2 rst_n = 1'b0;
        #1;
        check_val("midreset_rsp_valid", 64'(rsp_valid), 64'd0);
        check_val("midreset_req_ready", 64'(req_ready), 64'd0);
        check_val("midreset_rsp_rdata", rsp_rdata, 64'd0);
        sb_q.delete();
        model_reset();
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        send(CSR_OP_RS, 12'h305, 64'h0, 1'b1, 64'h0, 1'b1);
        send(CSR_OP_RS, 12'h300, 64'h0, 1'b1, 64'h0, 1'b1);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
